// File: rtl/rv_test_monitor.sv
// rv_test_monitor: watches the CPU test shell's retire interface, counts
// cycles and retires, and latches a sticky PASS / FAIL / TIMEOUT verdict.
// Optional feature macro: RVTM_PC_TRACE_EN adds an 8-entry retired-PC history
// with read ports hist_idx / hist_pc.
module rv_test_monitor #(
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned MAX_CYCLES   = 100000,
   parameter int unsigned DRAIN_CYCLES = 2,
   parameter logic [31:0] PASS_VAL     = 32'd1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wb,
   input  logic [31:0]      dbg_pc,
   input  logic             done,
   input  logic [31:0]      result_reg,
   output logic [2:0]       state,
   output logic             finished,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retire_cnt,
   output logic [31:0]      last_pc,
   output logic [31:0]      end_pc
`ifdef RVTM_PC_TRACE_EN
   ,
   input  logic [2:0]       hist_idx,
   output logic [31:0]      hist_pc
`endif
);

   localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST_RUN_CNT = CNT_W'(MAX_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RUN     = 3'd1,
      DRAIN   = 3'd2,
      PASS    = 3'd3,
      FAIL    = 3'd4,
      TIMEOUT = 3'd5
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_cycle_cnt;
   logic [CNT_W-1:0] r_retire_cnt;
   logic [CNT_W-1:0] w_cycle_inc;
   logic [CNT_W-1:0] w_retire_inc;
   logic [DW-1:0]    r_drain_cnt;
   logic [31:0]      r_last_pc;
   logic [31:0]      r_end_pc;
   logic             w_retire;

   assign w_retire     = (r_state == RUN) && wb;
   assign w_cycle_inc  = (r_cycle_cnt  == '1) ? r_cycle_cnt  : r_cycle_cnt  + CNT_W'(1);
   assign w_retire_inc = (r_retire_cnt == '1) ? r_retire_cnt : r_retire_cnt + CNT_W'(1);

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state decode; done wins over the timeout check in RUN
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    w_next_state = RUN;
         RUN: begin
            if (done)                             w_next_state = DRAIN;
            else if (r_cycle_cnt == LAST_RUN_CNT) w_next_state = TIMEOUT;
         end
         DRAIN: begin
            if (r_drain_cnt == DW'(1))
               w_next_state = (result_reg == PASS_VAL) ? PASS : FAIL;
         end
         default: w_next_state = r_state;
      endcase
   end

   // Counters and captured PCs; everything freezes in the terminal states
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cycle_cnt  <= '0;
         r_retire_cnt <= '0;
         r_drain_cnt  <= '0;
         r_last_pc    <= '0;
         r_end_pc     <= '0;
      end else begin
         case (r_state)
            RUN: begin
               r_cycle_cnt <= w_cycle_inc;
               if (wb) begin
                  r_retire_cnt <= w_retire_inc;
                  r_last_pc    <= dbg_pc;
               end
               if (done) begin
                  r_drain_cnt <= DW'(DRAIN_CYCLES);
                  r_end_pc    <= dbg_pc;
               end
            end
            DRAIN: begin
               r_cycle_cnt <= w_cycle_inc;
               r_drain_cnt <= r_drain_cnt - DW'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef RVTM_PC_TRACE_EN
   logic [31:0] r_hist [8];
   logic [2:0]  r_wptr;
   logic [2:0]  w_rd_idx;

   // Circular history of retired PCs, written only on counted retires
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr <= '0;
         for (int unsigned i = 0; i < 8; i++) r_hist[i] <= '0;
      end else if (w_retire) begin
         r_hist[r_wptr] <= dbg_pc;
         r_wptr         <= r_wptr + 3'd1;
      end
   end

   // Index 0 is the newest entry, counting back from the write pointer
   assign w_rd_idx = r_wptr - 3'd1 - hist_idx;
   assign hist_pc  = r_hist[w_rd_idx];
`endif

   assign state      = r_state;
   assign pass       = (r_state == PASS);
   assign fail       = (r_state == FAIL);
   assign timeout    = (r_state == TIMEOUT);
   assign finished   = pass || fail || timeout;
   assign cycle_cnt  = r_cycle_cnt;
   assign retire_cnt = r_retire_cnt;
   assign last_pc    = r_last_pc;
   assign end_pc     = r_end_pc;

endmodule

// File: tb/tb_rv_test_monitor.sv
// Self-checking bench for rv_test_monitor (MAX_CYCLES=100, DRAIN_CYCLES=2).
module tb_rv_test_monitor;

   logic        clk = 1'b0;
   logic        reset, wb, done;
   logic [31:0] dbg_pc, result_reg;
   logic [2:0]  state;
   logic        finished, pass, fail, timeout;
   logic [31:0] cycle_cnt, retire_cnt, last_pc, end_pc;
`ifdef RVTM_PC_TRACE_EN
   logic [2:0]  hist_idx;
   logic [31:0] hist_pc;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   rv_test_monitor #(
      .CNT_W(32), .MAX_CYCLES(100), .DRAIN_CYCLES(2), .PASS_VAL(32'd1)
   ) dut (
      .clk(clk), .reset(reset), .wb(wb), .dbg_pc(dbg_pc), .done(done),
      .result_reg(result_reg), .state(state), .finished(finished),
      .pass(pass), .fail(fail), .timeout(timeout), .cycle_cnt(cycle_cnt),
      .retire_cnt(retire_cnt), .last_pc(last_pc), .end_pc(end_pc)
`ifdef RVTM_PC_TRACE_EN
      , .hist_idx(hist_idx), .hist_pc(hist_pc)
`endif
   );

   typedef struct {
      logic        rst;
      logic        wb;
      logic        done;
      logic [31:0] pc;
      logic [31:0] x10;
      logic [2:0]  st;
      logic [31:0] cc;
      logic [31:0] rc;
      logic [31:0] lpc;
      logic [31:0] epc;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic w, input logic d, input logic [31:0] pc,
                      input logic [31:0] x, input logic [2:0] st, input logic [31:0] cc,
                      input logic [31:0] rc, input logic [31:0] lpc, input logic [31:0] epc);
      vec_t v;
      v.rst = r; v.wb = w; v.done = d; v.pc = pc; v.x10 = x;
      v.st = st; v.cc = cc; v.rc = rc; v.lpc = lpc; v.epc = epc;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // State plus the four flags decoded from the expected state
   task automatic check_state(input string name, input logic [2:0] exp_st);
      check({name, ".state"}, {29'd0, state}, {29'd0, exp_st});
      check({name, ".pass"}, {31'd0, pass}, {31'd0, exp_st == 3'd3});
      check({name, ".fail"}, {31'd0, fail}, {31'd0, exp_st == 3'd4});
      check({name, ".timeout"}, {31'd0, timeout}, {31'd0, exp_st == 3'd5});
      check({name, ".finished"}, {31'd0, finished},
            {31'd0, (exp_st == 3'd3) || (exp_st == 3'd4) || (exp_st == 3'd5)});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Two reset edges, then release; returns after the edge that enters RUN
   task automatic do_reset();
      reset = 1'b1; wb = 1'b0; done = 1'b0; dbg_pc = '0; result_reg = '0;
      tick(); tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      int rc_exp;
      logic [31:0] lpc_exp;
      logic saw_timeout;

      reset = 1'b1; wb = 1'b0; done = 1'b0; dbg_pc = '0; result_reg = '0;
`ifdef RVTM_PC_TRACE_EN
      hist_idx = '0;
`endif

      // T1 pass, then T2 fail with wb high on the done edge
      //   rst wb done pc      x10    st    cc  rc  lpc     epc
      add(1, 0, 0, 32'h00, 32'd0, 3'd0, 0, 0, 32'h00, 32'h00);
      add(1, 0, 0, 32'h00, 32'd0, 3'd0, 0, 0, 32'h00, 32'h00);
      add(0, 1, 1, 32'h99, 32'd0, 3'd1, 0, 0, 32'h00, 32'h00); // IDLE ignores wb/done
      add(0, 1, 0, 32'h00, 32'd0, 3'd1, 1, 1, 32'h00, 32'h00);
      add(0, 1, 0, 32'h04, 32'd0, 3'd1, 2, 2, 32'h04, 32'h00);
      add(0, 1, 0, 32'h08, 32'd0, 3'd1, 3, 3, 32'h08, 32'h00);
      add(0, 1, 0, 32'h0c, 32'd0, 3'd1, 4, 4, 32'h0c, 32'h00);
      add(0, 1, 0, 32'h10, 32'd0, 3'd1, 5, 5, 32'h10, 32'h00);
      add(0, 0, 1, 32'h14, 32'd1, 3'd2, 6, 5, 32'h10, 32'h14);
      add(0, 1, 1, 32'h18, 32'd1, 3'd2, 7, 5, 32'h10, 32'h14); // DRAIN ignores wb/done
      add(0, 0, 1, 32'h1c, 32'd1, 3'd3, 8, 5, 32'h10, 32'h14);
      add(0, 1, 1, 32'h20, 32'd0, 3'd3, 8, 5, 32'h10, 32'h14); // frozen
      add(1, 1, 1, 32'h20, 32'd1, 3'd0, 0, 0, 32'h00, 32'h00);
      add(0, 0, 0, 32'h00, 32'd1, 3'd1, 0, 0, 32'h00, 32'h00);
      add(0, 1, 0, 32'h00, 32'd1, 3'd1, 1, 1, 32'h00, 32'h00);
      add(0, 1, 0, 32'h04, 32'd1, 3'd1, 2, 2, 32'h04, 32'h00);
      add(0, 1, 1, 32'h08, 32'd0, 3'd2, 3, 3, 32'h08, 32'h08); // wb counted with done
      add(0, 0, 0, 32'h0c, 32'd1, 3'd2, 4, 3, 32'h08, 32'h08); // x10 not sampled yet
      add(0, 0, 0, 32'h10, 32'd0, 3'd4, 5, 3, 32'h08, 32'h08);

      foreach (tbl[i]) begin
         reset = tbl[i].rst; wb = tbl[i].wb; done = tbl[i].done;
         dbg_pc = tbl[i].pc; result_reg = tbl[i].x10;
         tick();
         check_state($sformatf("vec%0d", i), tbl[i].st);
         check($sformatf("vec%0d.cycle_cnt", i), cycle_cnt, tbl[i].cc);
         check($sformatf("vec%0d.retire_cnt", i), retire_cnt, tbl[i].rc);
         check($sformatf("vec%0d.last_pc", i), last_pc, tbl[i].lpc);
         check($sformatf("vec%0d.end_pc", i), end_pc, tbl[i].epc);
      end

      // T2 tail: FAIL held for 20 more cycles with busy inputs
      for (int i = 0; i < 20; i++) begin
         wb = 1'b1; done = i[0]; dbg_pc = 32'h100 + i; result_reg = 32'd1;
         tick();
      end
      check_state("t2_hold", 3'd4);
      check("t2_hold.cycle_cnt", cycle_cnt, 32'd5);
      check("t2_hold.retire_cnt", retire_cnt, 32'd3);

      // T3 timeout after 100 RUN cycles
      do_reset();
      check("t3_start.cycle_cnt", cycle_cnt, 32'd0);
      rc_exp = 0; lpc_exp = '0;
      for (int i = 1; i <= 100; i++) begin
         wb = i[0]; dbg_pc = i * 4;
         if (wb) begin rc_exp++; lpc_exp = i * 4; end
         tick();
         if (i == 99) begin
            check_state("t3_99", 3'd1);
            check("t3_99.cycle_cnt", cycle_cnt, 32'd99);
         end
      end
      check_state("t3_to", 3'd5);
      check("t3_to.cycle_cnt", cycle_cnt, 32'd100);
      check("t3_to.retire_cnt", retire_cnt, rc_exp);
      check("t3_to.last_pc", last_pc, lpc_exp);
      wb = 1'b1; done = 1'b1; dbg_pc = 32'hdead; result_reg = 32'd1;
      for (int i = 0; i < 5; i++) tick();
      check_state("t3_frz", 3'd5);
      check("t3_frz.cycle_cnt", cycle_cnt, 32'd100);
      check("t3_frz.retire_cnt", retire_cnt, rc_exp);
      check("t3_frz.end_pc", end_pc, 32'h0);

      // T4 reset on the edge after done
      do_reset();
      wb = 1'b1; dbg_pc = 32'h40; tick();
      wb = 1'b0; done = 1'b1; dbg_pc = 32'h44; result_reg = 32'd1; tick();
      check_state("t4_drain", 3'd2);
      reset = 1'b1; done = 1'b0; tick();
      check_state("t4_rst", 3'd0);
      check("t4_rst.cycle_cnt", cycle_cnt, 32'd0);
      check("t4_rst.retire_cnt", retire_cnt, 32'd0);
      check("t4_rst.last_pc", last_pc, 32'd0);
      check("t4_rst.end_pc", end_pc, 32'd0);
      reset = 1'b0; tick();
      check_state("t4_run", 3'd1);
      check("t4_run.cycle_cnt", cycle_cnt, 32'd0);
      tick();
      check("t4_run2.cycle_cnt", cycle_cnt, 32'd1);
      tick(); tick();
      check_state("t4_nodrain", 3'd1);

      // T5 done on the same edge as the timeout threshold
      do_reset();
      for (int i = 0; i < 99; i++) tick();
      check("t5_99.cycle_cnt", cycle_cnt, 32'd99);
      done = 1'b1; dbg_pc = 32'h80; result_reg = 32'd1;
      saw_timeout = 1'b0;
      tick();
      check_state("t5_drain", 3'd2);
      check("t5_drain.cycle_cnt", cycle_cnt, 32'd100);
      for (int i = 0; i < 2; i++) begin
         if (timeout) saw_timeout = 1'b1;
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         if (timeout) saw_timeout = 1'b1;
         tick();
      end
      check_state("t5_pass", 3'd3);
      check("t5_pass.cycle_cnt", cycle_cnt, 32'd102);
      check("t5_pass.end_pc", end_pc, 32'h80);
      check("t5_no_timeout", {31'd0, saw_timeout}, 32'd0);

`ifdef RVTM_PC_TRACE_EN
      // T6 PC history
      do_reset();
      done = 1'b0;
      hist_idx = 3'd0; #1;
      check("t6_empty", hist_pc, 32'd0);
      for (int i = 0; i < 10; i++) begin
         wb = 1'b1; dbg_pc = i * 4; tick();
      end
      wb = 1'b0;
      hist_idx = 3'd0; #1; check("t6_idx0", hist_pc, 32'd36);
      hist_idx = 3'd1; #1; check("t6_idx1", hist_pc, 32'd32);
      hist_idx = 3'd7; #1; check("t6_idx7", hist_pc, 32'd8);
      done = 1'b1; wb = 1'b1; dbg_pc = 32'h200; tick();
      done = 1'b0; dbg_pc = 32'h204; tick();
      hist_idx = 3'd0; #1; check("t6_frz", hist_pc, 32'h200);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Absolute time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
